// File: rtl/idct_transpose4.sv
// -----------------------------------------------------------------------------
// idct_transpose4
// 4x4 transpose buffer that sits between the row pass and the column pass of
// a 2-D IDCT.
//
// The row pass delivers one 4x4 block as 16 serial samples in row-major order
// (r0c0, r0c1, ..., r3c3). The samples have already been rounded. This block
// stores a whole block and then replays it in column-major order
// (r0c0, r1c0, ..., r3c3) to the column pass.
//
// Two storage banks of 16 words each work as a ping-pong pair, so one block
// can fill while the other drains. Each replayed sample is saturated to a
// signed OW-bit value.
//
// Parameters
//   DW : width of the signed input samples
//   OW : width of the signed, saturated output samples
//
// Ports
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset
//   in_valid  : in_data carries a valid row-pass sample
//   in_ready  : buffer accepts in_data this cycle
//   in_data   : signed DW-bit sample, row-major within a block
//   out_valid : out_data carries a valid transposed sample
//   out_ready : downstream accepts out_data this cycle
//   out_data  : signed OW-bit saturated sample, column-major
//   out_last  : high together with the 16th sample of a block
// -----------------------------------------------------------------------------
module idct_transpose4 #(
    parameter int unsigned DW = 25,
    parameter int unsigned OW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last
);

    // Clamp a signed DW-bit value into the signed OW-bit range.
    function automatic logic [OW-1:0] sat_to_ow(input logic [DW-1:0] v);
        logic signed [DW-1:0] v_s;
        logic signed [DW-1:0] max_s;
        logic signed [DW-1:0] min_s;
        logic [OW-1:0]        res;
        v_s   = $signed(v);
        max_s = $signed({{(DW-OW+1){1'b0}}, {(OW-1){1'b1}}});
        min_s = $signed({{(DW-OW+1){1'b1}}, {(OW-1){1'b0}}});
        if (v_s > max_s) begin
            res = max_s[OW-1:0];
        end else if (v_s < min_s) begin
            res = min_s[OW-1:0];
        end else begin
            // In range: the upper bits are pure sign extension, so
            // truncating keeps the value.
            res = v[OW-1:0];
        end
        return res;
    endfunction

    // Ping-pong storage, indexed [bank][row*4 + col].
    // The storage is not reset; the full flags decide what is meaningful.
    logic [DW-1:0] mem_q [2][16];

    logic       wr_bank_q, wr_bank_d;
    logic [3:0] wr_idx_q,  wr_idx_d;
    logic       rd_bank_q, rd_bank_d;
    logic [3:0] rd_idx_q,  rd_idx_d;
    logic [1:0] full_q,    full_d;

    logic          wr_fire_s;
    logic          rd_fire_s;
    logic [3:0]    rd_addr_s;
    logic [DW-1:0] rd_word_s;

    // Handshake decode.
    // Both ready and valid come only from flops, so no combinational path
    // runs from the input side to the output side.
    always_comb begin
        in_ready  = ~full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        wr_fire_s = in_valid & in_ready;
        rd_fire_s = out_valid & out_ready;
    end

    // Read data path.
    // Swapping the index nibbles turns the column-major read counter into the
    // row-major storage address (row = rd_idx[1:0], col = rd_idx[3:2]).
    always_comb begin
        rd_addr_s = {rd_idx_q[1:0], rd_idx_q[3:2]};
        rd_word_s = mem_q[rd_bank_q][rd_addr_s];
        if (out_valid) begin
            out_data = sat_to_ow(rd_word_s);
            out_last = (rd_idx_q == 4'd15);
        end else begin
            out_data = {OW{1'b0}};
            out_last = 1'b0;
        end
    end

    // Next-state logic for the write and read pointers and the per-bank full
    // flags.
    // Finishing a write and finishing a read in the same cycle always touch
    // different banks, because the full flag stops a bank being written while
    // it is being read. The two updates therefore never collide.
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        full_d    = full_q;

        if (wr_fire_s) begin
            if (wr_idx_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = 4'd0;
            end else begin
                wr_idx_d = wr_idx_q + 4'd1;
            end
        end else begin
            wr_idx_d = wr_idx_q;
        end

        if (rd_fire_s) begin
            if (rd_idx_q == 4'd15) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                rd_idx_d          = 4'd0;
            end else begin
                rd_idx_d = rd_idx_q + 4'd1;
            end
        end else begin
            rd_idx_d = rd_idx_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_q <= 1'b0;
            wr_idx_q  <= 4'd0;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= 4'd0;
            full_q    <= 2'b00;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
            full_q    <= full_d;
        end
    end

    // Sample storage write port. A bank is only written while its full flag
    // is clear.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_q[wr_bank_q][wr_idx_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_idct_transpose4.sv
module tb_idct_transpose4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    idct_transpose4 #(.DW(25), .OW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t        sb_q[$];
    logic [24:0] blk [16];
    int          blk_cnt;
    int          acc_cnt;
    bit          stall_q;
    int          held_data;
    bit          held_last;
    int          checks;
    int          errors;

    task automatic check_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference saturation to signed 16 bits.
    function automatic int sat_model(input logic [24:0] x);
        logic signed [24:0] xs;
        int v;
        xs = x;
        v  = xs;
        if (v > 32767) return 32767;
        else if (v < -32768) return -32768;
        else return v;
    endfunction

    function automatic logic [24:0] rand_word();
        int sel;
        int v;
        sel = $urandom_range(0, 3);
        if (sel == 0) begin
            return 25'($urandom());
        end else if (sel == 1) begin
            v = $urandom_range(0, 40);
            return 25'(32748 + v);
        end else if (sel == 2) begin
            v = $urandom_range(0, 40);
            return 25'(-32788 + v);
        end else begin
            v = $urandom_range(0, 2000);
            return 25'(v - 1000);
        end
    endfunction

    task automatic sb_flush();
        sb_q.delete();
        blk_cnt = 0;
        acc_cnt = 0;
        stall_q = 1'b0;
    endtask

    // Monitor and model. The handshake is sampled mid-cycle.
    // Accepted inputs go into a block model. When a block completes, its 16
    // transposed and saturated expectations are queued. Each output transfer
    // pops one expectation from the queue and compares against it.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (in_valid && in_ready) begin
                    blk[blk_cnt] = in_data;
                    acc_cnt++;
                    if (blk_cnt == 15) begin
                        for (int k = 0; k < 16; k++) begin
                            exp_t e;
                            e.data = sat_model(blk[(k % 4) * 4 + (k / 4)]);
                            e.last = (k == 15);
                            sb_q.push_back(e);
                        end
                        blk_cnt = 0;
                    end else begin
                        blk_cnt++;
                    end
                end
                if (stall_q) begin
                    check_eq("stall_valid", int'(out_valid), 1);
                    check_eq("stall_data", int'($signed(out_data)), held_data);
                    check_eq("stall_last", int'(out_last), int'(held_last));
                end
                if (!out_valid) begin
                    check_eq("idle_data_zero", int'(out_data), 0);
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check_eq("unexpected_output", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check_eq("out_data", int'($signed(out_data)), e.data);
                        check_eq("out_last", int'(out_last), int'(e.last));
                    end
                end
                stall_q   = out_valid && !out_ready;
                held_data = int'($signed(out_data));
                held_last = out_last;
            end
        end
    end

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 25'd0;
        reset     = 1'b0;
        sb_flush();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", int'(out_valid), 0);
        reset = 1'b1;
        #1;
        check_eq("rst_in_ready", int'(in_ready), 1);
        check_eq("rst_out_valid_rel", int'(out_valid), 0);
        check_eq("rst_out_last", int'(out_last), 0);
        check_eq("rst_out_data", int'(out_data), 0);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({nm, "_drain_timeout"}, int'(n >= 300), 0);
        check_eq({nm, "_queue_empty"}, sb_q.size(), 0);
        check_eq({nm, "_partial_block"}, blk_cnt, 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int          sent;
        int          cyc;
        int          drops;
        int          gaps;
        bit          acc;
        logic [24:0] cur;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 25'd0;
        #2;

        // Test 1: one block 0..15, transpose order, 1-cycle latency.
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 25'(i);
            @(posedge clk);
            #1;
            if (i == 14) check_eq("t1_valid_before_last_in", int'(out_valid), 0);
            if (i == 15) begin
                check_eq("t1_valid_after_last_in", int'(out_valid), 1);
                check_eq("t1_first_data", int'(out_data), 0);
                check_eq("t1_first_last", int'(out_last), 0);
            end
        end
        in_valid = 1'b0;
        drain("t1");

        // Test 2: backpressure fills both banks, then release.
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_data  = 25'(i + 1000);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_eq("t2_accepted", acc_cnt, 32);
        check_eq("t2_in_ready_full", int'(in_ready), 0);
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk);
            #1;
            if (j == 14) check_eq("t2_in_ready_before_free", int'(in_ready), 0);
            if (j == 15) check_eq("t2_in_ready_after_free", int'(in_ready), 1);
        end
        drain("t2");

        // Test 3: saturation at transposed positions.
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            case (i)
                0: in_data = 25'sd40000;
                1: in_data = -25'sd40000;
                2: in_data = 25'sd32767;
                3: in_data = -25'sd32768;
                4: in_data = 25'h0FFFFFF;
                default: in_data = 25'(i * 3 - 20);
            endcase
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_eq("t3_first_sat", int'($signed(out_data)), 32767);
        drain("t3");

        // Test 4: random valid/ready over 100 blocks.
        apply_reset();
        sent = 0;
        cyc  = 0;
        cur  = rand_word();
        while (sent < 1600 && cyc < 40000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = cur;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                cur = rand_word();
            end
            cyc++;
        end
        check_eq("t4_sent", sent, 1600);
        drain("t4");

        // Test 5: reset mid-operation, then a fresh block.
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 23; i++) begin
            in_valid = 1'b1;
            in_data  = 25'(200 + i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        sb_flush();
        #1;
        check_eq("t5_valid_at_reset", int'(out_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("t5_in_ready_after_reset", int'(in_ready), 1);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 25'(100 + i);
            @(posedge clk);
            #1;
            if (i == 15) begin
                check_eq("t5_valid_after_block", int'(out_valid), 1);
                check_eq("t5_first_data", int'(out_data), 100);
            end
        end
        in_valid = 1'b0;
        drain("t5");

        // Test 6: continuous streaming of 4 blocks.
        apply_reset();
        out_ready = 1'b1;
        drops = 0;
        gaps  = 0;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = 25'(i * 7 - 100);
            @(negedge clk);
            if (!in_ready) drops++;
            if (i >= 16 && !out_valid) gaps++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_eq("t6_in_ready_drops", drops, 0);
        check_eq("t6_out_valid_gaps", gaps, 0);
        check_eq("t6_accepted", acc_cnt, 64);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
